// File: rtl/capture_sequencer.sv
// capture_sequencer: photobooth capture controller.
// Once the start screen is finished (enable_in high), a shutter click latches
// the chosen filter and starts a per-shot seconds countdown. When a countdown
// expires, one camera frame is captured. After NUM_SHOTS shots the block
// reports done, and a further click in DONE starts a retake.
//
// Ports:
//   clk_in          pixel clock (single domain)
//   rst_n_in        asynchronous active-low reset
//   enable_in       start screen finished; low forces IDLE
//   select_in       filter index 0..5, sampled on a click
//   shutter_in      debounced button level; the rising edge is a click
//   frame_start_in  one-cycle pulse at the start of a camera frame
//   frame_done_in   one-cycle pulse when the frame has been stored
//   filter_out      latched filter index
//   countdown_out   seconds remaining; 0 outside COUNT
//   capture_out     high for the whole capture window
//   shot_idx_out    buffer slot of the current/next shot
//   busy_out        high in COUNT, WAIT_FRAME, CAPTURE
//   done_out        high in DONE
//
// state      | meaning
// -----------+--------------------------------------------------
// IDLE       | waiting for enable_in
// ARMED      | waiting for the first shutter click
// COUNT      | seconds countdown for the current shot
// WAIT_FRAME | countdown expired, waiting for frame_start_in
// CAPTURE    | capture window open, waiting for frame_done_in
// DONE       | all shots taken; a click starts a retake
module capture_sequencer #(
  parameter int unsigned CLK_HZ        = 74_250_000,
  parameter int unsigned COUNT_SECONDS = 3,
  parameter int unsigned NUM_SHOTS     = 4
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       enable_in,
  input  logic [2:0] select_in,
  input  logic       shutter_in,
  input  logic       frame_start_in,
  input  logic       frame_done_in,
  output logic [2:0] filter_out,
  output logic [3:0] countdown_out,
  output logic       capture_out,
  output logic [1:0] shot_idx_out,
  output logic       busy_out,
  output logic       done_out
);

  localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);
  localparam logic [3:0]    CD_LOAD   = 4'(COUNT_SECONDS);
  localparam logic [1:0]    LAST_SHOT = 2'(NUM_SHOTS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ARMED, S_COUNT, S_WAIT_FRAME, S_CAPTURE, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          shutter_q;
  logic [2:0]    filter_q, filter_d;
  logic [3:0]    countdown_q, countdown_d;
  logic          capture_q, capture_d;
  logic [1:0]    shot_idx_q, shot_idx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          click;

  assign click = shutter_in & ~shutter_q;

  always_comb begin
    state_d     = state_q;
    presc_d     = presc_q;
    filter_d    = filter_q;
    countdown_d = countdown_q;
    capture_d   = capture_q;
    shot_idx_d  = shot_idx_q;

    if (!enable_in) begin
      // filter_out deliberately survives a drop of enable
      state_d     = S_IDLE;
      presc_d     = '0;
      countdown_d = '0;
      capture_d   = 1'b0;
      shot_idx_d  = '0;
    end else begin
      unique case (state_q)
        S_IDLE: state_d = S_ARMED;
        S_ARMED, S_DONE: begin
          if (click) begin
            filter_d    = (select_in > 3'd5) ? 3'd0 : select_in;
            shot_idx_d  = '0;
            countdown_d = CD_LOAD;
            presc_d     = '0;
            state_d     = S_COUNT;
          end
        end
        S_COUNT: begin
          if (presc_q == PRESC_MAX) begin
            presc_d = '0;
            if (countdown_q > 4'd1) begin
              countdown_d = countdown_q - 4'd1;
            end else begin
              countdown_d = '0;
              state_d     = S_WAIT_FRAME;
            end
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
        S_WAIT_FRAME: begin
          if (frame_start_in) begin
            capture_d = 1'b1;
            state_d   = S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          if (frame_done_in) begin
            capture_d = 1'b0;
            if (shot_idx_q < LAST_SHOT) begin
              shot_idx_d  = shot_idx_q + 2'd1;
              countdown_d = CD_LOAD;
              presc_d     = '0;
              state_d     = S_COUNT;
            end else begin
              state_d = S_DONE;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    busy_d = (state_d == S_COUNT) || (state_d == S_WAIT_FRAME) ||
             (state_d == S_CAPTURE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= S_IDLE;
      presc_q     <= '0;
      shutter_q   <= 1'b0;
      filter_q    <= '0;
      countdown_q <= '0;
      capture_q   <= 1'b0;
      shot_idx_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      shutter_q   <= shutter_in;
      filter_q    <= filter_d;
      countdown_q <= countdown_d;
      capture_q   <= capture_d;
      shot_idx_q  <= shot_idx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign filter_out    = filter_q;
  assign countdown_out = countdown_q;
  assign capture_out   = capture_q;
  assign shot_idx_out  = shot_idx_q;
  assign busy_out      = busy_q;
  assign done_out      = done_q;

endmodule

// File: tb/tb_capture_sequencer.sv
module tb_capture_sequencer;

  logic       clk_in = 1'b0;
  logic       rst_n_in = 1'b1;
  logic       enable_in = 1'b0;
  logic [2:0] select_in = '0;
  logic       shutter_in = 1'b0;
  logic       frame_start_in = 1'b0;
  logic       frame_done_in = 1'b0;
  logic [2:0] filter_out;
  logic [3:0] countdown_out;
  logic       capture_out;
  logic [1:0] shot_idx_out;
  logic       busy_out;
  logic       done_out;

  int n_vec = 0;
  int n_err = 0;

  capture_sequencer #(.CLK_HZ(10), .COUNT_SECONDS(2), .NUM_SHOTS(2)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .enable_in(enable_in),
    .select_in(select_in), .shutter_in(shutter_in),
    .frame_start_in(frame_start_in), .frame_done_in(frame_done_in),
    .filter_out(filter_out), .countdown_out(countdown_out),
    .capture_out(capture_out), .shot_idx_out(shot_idx_out),
    .busy_out(busy_out), .done_out(done_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic       en;
    logic [2:0] sel;
    logic       sh, fs, fd;
    int         n;      // clock edges to hold the inputs before checking
    logic [2:0] filt;
    logic [3:0] cd;
    logic       cap;
    logic [1:0] shot;
    logic       busy, done;
  } vec_t;

  vec_t vecs[25];

  function automatic vec_t mk(logic en, logic [2:0] sel, logic sh, logic fs,
                              logic fd, int n, logic [2:0] filt, logic [3:0] cd,
                              logic cap, logic [1:0] shot, logic busy, logic done);
    vec_t v;
    v.en = en; v.sel = sel; v.sh = sh; v.fs = fs; v.fd = fd; v.n = n;
    v.filt = filt; v.cd = cd; v.cap = cap; v.shot = shot;
    v.busy = busy; v.done = done;
    return v;
  endfunction

  task automatic check(string name, logic [2:0] f, logic [3:0] c, logic cap,
                       logic [1:0] s, logic b, logic d);
    n_vec++;
    if ({filter_out, countdown_out, capture_out, shot_idx_out, busy_out, done_out}
        !== {f, c, cap, s, b, d}) begin
      n_err++;
      $display("FAIL %s: got filt=%0d cd=%0d cap=%0b shot=%0d busy=%0b done=%0b, expected filt=%0d cd=%0d cap=%0b shot=%0d busy=%0b done=%0b",
               name, filter_out, countdown_out, capture_out, shot_idx_out,
               busy_out, done_out, f, c, cap, s, b, d);
    end
  endtask

  initial begin
    //                en sel sh fs fd  n  filt cd cap shot busy done
    vecs[0]  = mk(1, 4, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0); // IDLE -> ARMED
    vecs[1]  = mk(1, 4, 1, 0, 0,  1, 4, 2, 0, 0, 1, 0); // click: t+1
    vecs[2]  = mk(1, 4, 1, 0, 0,  9, 4, 2, 0, 0, 1, 0); // t+10 still 2
    vecs[3]  = mk(1, 4, 0, 0, 0,  1, 4, 1, 0, 0, 1, 0); // t+11 -> 1
    vecs[4]  = mk(1, 4, 1, 0, 0,  1, 4, 1, 0, 0, 1, 0); // click in COUNT ignored
    vecs[5]  = mk(1, 4, 0, 0, 0,  8, 4, 1, 0, 0, 1, 0); // t+20 still 1
    vecs[6]  = mk(1, 4, 0, 0, 0,  1, 4, 0, 0, 0, 1, 0); // t+21 WAIT_FRAME
    vecs[7]  = mk(1, 4, 0, 0, 1,  1, 4, 0, 0, 0, 1, 0); // frame_done in WAIT ignored
    vecs[8]  = mk(1, 4, 0, 1, 1,  1, 4, 0, 1, 0, 1, 0); // start+done same cycle
    vecs[9]  = mk(1, 4, 0, 0, 0,  3, 4, 0, 1, 0, 1, 0); // window stays open
    vecs[10] = mk(1, 4, 0, 1, 0,  1, 4, 0, 1, 0, 1, 0); // repeat frame_start ignored
    vecs[11] = mk(1, 4, 0, 0, 1,  1, 4, 2, 0, 1, 1, 0); // frame_done: next shot
    vecs[12] = mk(1, 4, 0, 0, 0,  9, 4, 2, 0, 1, 1, 0);
    vecs[13] = mk(1, 4, 0, 0, 0,  1, 4, 1, 0, 1, 1, 0);
    vecs[14] = mk(1, 4, 0, 0, 0, 10, 4, 0, 0, 1, 1, 0);
    vecs[15] = mk(1, 4, 0, 1, 0,  1, 4, 0, 1, 1, 1, 0);
    vecs[16] = mk(1, 4, 0, 0, 1,  1, 4, 0, 0, 1, 0, 1); // last shot -> DONE
    vecs[17] = mk(1, 4, 0, 0, 0,  2, 4, 0, 0, 1, 0, 1);
    vecs[18] = mk(1, 2, 1, 0, 0,  1, 2, 2, 0, 0, 1, 0); // retake
    vecs[19] = mk(1, 7, 0, 0, 0, 19, 2, 1, 0, 0, 1, 0); // select change ignored
    vecs[20] = mk(1, 7, 0, 0, 0,  1, 2, 0, 0, 0, 1, 0);
    vecs[21] = mk(1, 7, 0, 1, 0,  1, 2, 0, 1, 0, 1, 0);
    vecs[22] = mk(0, 7, 0, 0, 0,  1, 2, 0, 0, 0, 0, 0); // enable drop in CAPTURE
    vecs[23] = mk(1, 7, 0, 0, 0,  1, 2, 0, 0, 0, 0, 0); // back to ARMED
    vecs[24] = mk(1, 7, 1, 0, 0,  1, 0, 2, 0, 0, 1, 0); // invalid select -> 0

    #1 rst_n_in = 1'b0;
    #2 check("reset", 0, 0, 0, 0, 0, 0);
    @(negedge clk_in);
    rst_n_in = 1'b1;

    for (int i = 0; i < 25; i++) begin
      enable_in      = vecs[i].en;
      select_in      = vecs[i].sel;
      shutter_in     = vecs[i].sh;
      frame_start_in = vecs[i].fs;
      frame_done_in  = vecs[i].fd;
      repeat (vecs[i].n) @(posedge clk_in);
      #1 check($sformatf("vec%0d", i), vecs[i].filt, vecs[i].cd, vecs[i].cap,
               vecs[i].shot, vecs[i].busy, vecs[i].done);
      @(negedge clk_in);
    end

    // asynchronous reset mid-COUNT, observed before any clock edge
    shutter_in = 1'b0;
    repeat (3) @(posedge clk_in);
    #2 rst_n_in = 1'b0;
    #1 check("async_reset", 0, 0, 0, 0, 0, 0);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    @(posedge clk_in);
    #1 check("armed_after_reset", 0, 0, 0, 0, 0, 0);
    @(negedge clk_in);
    select_in  = 3'd5;
    shutter_in = 1'b1;
    @(posedge clk_in);
    #1 check("click_after_reset", 5, 2, 0, 0, 1, 0);
    @(negedge clk_in);
    shutter_in = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/capture_sequencer.md
# capture_sequencer

Photobooth capture controller that sits directly downstream of the start/filter-select screen. It takes over once the start screen reports completion. It latches the chosen filter on a shutter press and runs a per-shot seconds countdown. It then opens one camera-frame capture window per shot for a fixed number of shots and reports done. The display path uses its countdown and slot outputs; the frame-buffer writer uses its capture window.

## Interface
Parameters:
- CLK_HZ, 74_250_000, clock cycles per countdown second
- COUNT_SECONDS, 3, countdown length per shot (1..15)
- NUM_SHOTS, 4, shots per session (1..4)

Ports:
- clk_in  input  1  pixel clock; single clock domain
- rst_n_in  input  1  asynchronous, active-low reset
- enable_in  input  1  level; high once the start screen is finished
- select_in  input  3  filter index from the select screen, valid values 0..5
- shutter_in  input  1  debounced button level; block detects rising edge internally
- frame_start_in  input  1  one-cycle pulse at the start of a camera frame
- frame_done_in  input  1  one-cycle pulse when the buffer writer has stored the frame
- filter_out  output  3  latched filter index
- countdown_out  output  4  seconds remaining; 0 outside COUNT
- capture_out  output  1  high for the whole capture window
- shot_idx_out  output  2  buffer slot of the current/next shot
- busy_out  output  1  high in COUNT, WAIT_FRAME, CAPTURE
- done_out  output  1  high in DONE

## Operation
- States: IDLE, ARMED, COUNT, WAIT_FRAME, CAPTURE, DONE.
- Reset (asynchronous, any time) sets outputs and internal state as follows:
  - state IDLE; all outputs 0
  - prescaler 0; shutter edge register 0
- enable_in low in any state forces IDLE on the next edge. It also clears capture_out, countdown_out, busy_out, done_out and shot_idx_out. filter_out holds its value.
- IDLE: when enable_in is high, go to ARMED.
- ARMED:
  - A shutter click is shutter_in high with the previous sample low.
  - On a click, latch filter_out = select_in, or 0 if select_in > 5.
  - Also set shot_idx_out = 0, load countdown_out = COUNT_SECONDS, clear the prescaler, and go to COUNT.
- COUNT:
  - The prescaler counts 0..CLK_HZ-1 and then wraps; each wrap is one tick.
  - A tick with countdown_out > 1 decrements countdown_out.
  - A tick with countdown_out == 1 sets countdown_out = 0 and goes to WAIT_FRAME.
  - Shutter clicks are ignored.
- WAIT_FRAME: frame_start_in sets capture_out = 1 and goes to CAPTURE. A frame_done_in pulse in the same cycle is ignored.
- CAPTURE: frame_done_in clears capture_out. Then:
  - if shot_idx_out < NUM_SHOTS-1, increment shot_idx_out, reload countdown_out = COUNT_SECONDS, clear the prescaler, and go to COUNT;
  - otherwise go to DONE with shot_idx_out held.
- DONE: done_out = 1. A shutter click is a retake: relatch the filter and follow the ARMED-click behaviour, going to COUNT.
- frame_start_in and frame_done_in are ignored outside WAIT_FRAME and CAPTURE respectively. In CAPTURE a repeated frame_start_in is ignored.
- select_in changes after the latch have no effect until the next ARMED or DONE click.

## Timing
- All outputs are registered.
- Shutter edge at cycle t (shutter_in high at t, low at t-1):
  - state COUNT, countdown_out = COUNT_SECONDS and busy_out = 1 from t+1;
  - filter_out valid from t+1.
- The COUNT phase lasts exactly COUNT_SECONDS*CLK_HZ cycles. countdown_out changes every CLK_HZ cycles.
- frame_start_in at cycle f: capture_out = 1 from f+1.
- frame_done_in at cycle d: capture_out = 0 from d+1. shot_idx_out increments (or done_out = 1) at d+1.
- Prescaler width is clog2(CLK_HZ); it runs only in COUNT.

## Test plan
Unless stated otherwise, tests use CLK_HZ=10, COUNT_SECONDS=2, NUM_SHOTS=2.
- Reset/enable: assert rst_n_in low mid-COUNT -> all outputs 0 immediately (asynchronous); release with enable_in=1 -> ARMED one cycle later; countdown_out=0.
- Countdown: select_in=4, shutter rising edge at t -> filter_out=4 and countdown_out=2 at t+1, 1 at t+11, 0 with WAIT_FRAME at t+21.
- Capture handshake: frame_start at f -> capture_out high f+1..d, low at d+1 after frame_done at d; shot_idx_out=1 and countdown_out=2 at d+1; a second cycle ends with done_out=1 and shot_idx_out=1.
- Invalid/ignored inputs:
  - select_in=7 at click -> filter_out=0;
  - shutter pulses during COUNT -> no timing change;
  - frame_done in WAIT_FRAME -> no effect;
  - frame_start and frame_done in the same cycle -> CAPTURE entered, capture_out still high next cycle.
- Enable drop: deassert enable_in during CAPTURE -> IDLE, capture_out=0 next cycle; reassert -> ARMED, shot_idx_out=0.
- Retake: click in DONE with select_in=2 -> filter_out=2, shot_idx_out=0, countdown_out=2, done_out=0 next cycle.
